// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
// Contents:
//   state_e       FSM state type (idle / run / done)
//   DefaultWidth  default operand width
//   MostNeg       most-negative two's complement value at the default width
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [DefaultWidth-1:0] MostNeg = {1'b1, {(DefaultWidth-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes.
// Ports:
//   rem_in        partial remainder before the step (always < divisor)
//   divisor       divisor magnitude
//   dividend_bit  next dividend bit, MSB first
//   rem_out       partial remainder after the step
//   quo_bit       quotient bit produced by the step
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             quo_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor keeps shifted below 2^WIDTH, so diff's top bit is a valid borrow flag.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    quo_bit = ~diff[WIDTH];
    rem_out = quo_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider: one restoring step per cycle on operand magnitudes,
// followed by a sign-correction cycle. Divide-by-zero and most-negative / -1
// bypass the iteration and raise data_exception.
// Ports:
//   clock, reset     clock and asynchronous active-high reset
//   data_operandA/B  dividend / divisor (two's complement), latched on start
//   ctrl_DIV         start request
//   data_result      quotient,  registered, held until the next result
//   data_remainder   remainder, registered, held until the next result
//   data_exception   divide-by-zero / overflow flag for the presented result
//   data_resultRDY   one-cycle pulse when a result is presented
//   busy             high while iterating
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state;
  logic [CntW-1:0]  count;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] dvd;    // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dsr;    // divisor magnitude
  logic [WIDTH-1:0] rem;    // partial remainder
  logic [WIDTH-1:0] quo;    // quotient magnitude, shifted in LSB first
  logic             pend;   // special-case result waits one edge in idle

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    a_mag    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    div_zero = (data_operandB == '0);
    div_ovf  = (data_operandA == MinVal) && (data_operandB == '1);
    // A zero quotient negates to itself, so no explicit non-zero test is needed.
    quo_fix  = (op_a[WIDTH-1] ^ op_b[WIDTH-1]) ? -quo : quo;
    rem_fix  = op_a[WIDTH-1] ? -rem : rem;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in      (rem),
    .divisor     (dsr),
    .dividend_bit(dvd[WIDTH-1]),
    .rem_out     (step_rem),
    .quo_bit     (step_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= StIdle;
      count          <= '0;
      op_a           <= '0;
      op_b           <= '0;
      dvd            <= '0;
      dsr            <= '0;
      rem            <= '0;
      quo            <= '0;
      pend           <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if (state == StIdle && pend) begin
            // Present the bypassed result; a start here is not accepted.
            pend           <= 1'b0;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
            state          <= StDone;
            if (op_b == '0) begin
              data_result    <= '0;
              data_remainder <= op_a;
            end else begin
              data_result    <= MinVal;
              data_remainder <= '0;
            end
          end else if (ctrl_DIV) begin
            op_a  <= data_operandA;
            op_b  <= data_operandB;
            dvd   <= a_mag;
            dsr   <= b_mag;
            rem   <= '0;
            quo   <= '0;
            count <= '0;
            if (div_zero || div_ovf) begin
              pend  <= 1'b1;
              state <= StIdle;
            end else begin
              data_exception <= 1'b0;
              busy           <= 1'b1;
              state          <= StRun;
            end
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          if (count == LastCnt) begin
            data_result    <= quo_fix;
            data_remainder <= rem_fix;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= StDone;
          end else begin
            rem   <= step_rem;
            quo   <= {quo[WIDTH-2:0], step_q};
            dvd   <= {dvd[WIDTH-2:0], 1'b0};
            count <= count + CntW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         exc;
    int           cyc;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_result;
  logic [W-1:0] data_remainder;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  exp_t sb[$];

  div_unit #(
    .WIDTH(W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_remainder(data_remainder),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      if (sb.size() == 0) begin
        chk("unexpected_rdy", 32'(data_resultRDY), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", data_result, e.res);
        chk("remainder", data_remainder, e.rem);
        chk("exception", 32'(data_exception), 32'(e.exc));
        chk("latency", 32'(cyc), 32'(e.cyc));
        chk("busy_at_rdy", 32'(busy), 32'd0);
      end
    end
  end

  // Called at a negedge: drive a one-cycle start and queue the expected answer.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r,
                       input logic [W-1:0] m, input logic e, input bit special);
    exp_t x;
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    x.res = r;
    x.rem = m;
    x.exc = e;
    x.cyc = cyc + (special ? 2 : W + 2);
    sb.push_back(x);
    @(negedge clock);
    ctrl_DIV = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clock);
    chk("rst_result", data_result, '0);
    chk("rst_remainder", data_remainder, '0);
    chk("rst_exception", 32'(data_exception), 32'd0);
    chk("rst_rdy", 32'(data_resultRDY), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    issue(32'd35, 32'd16, 32'd2, 32'd3, 1'b0, 1'b0);
    chk("busy_in_run", 32'(busy), 32'd1);
    drain();
    issue(-32'sd35, 32'd16, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0);
    drain();
    issue(32'd35, -32'sd16, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    drain();
    issue(-32'sd35, -32'sd16, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
    drain();
    issue(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
    drain();
    issue(MostNeg, 32'd2, 32'hC000_0000, 32'd0, 1'b0, 1'b0);
    drain();
    issue(MostNeg, 32'd1, MostNeg, 32'd0, 1'b0, 1'b0);
    drain();
    issue(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    drain();

    // Exceptional cases bypass the iteration.
    issue(32'd7, 32'd0, 32'd0, 32'd7, 1'b1, 1'b1);
    drain();
    issue(MostNeg, 32'hFFFF_FFFF, MostNeg, 32'd0, 1'b1, 1'b1);
    drain();
    // A normal division after an exception must clear the flag.
    issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
    drain();

    // Start during run is ignored.
    k = cyc;
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    while (cyc < k + 10) @(negedge clock);
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    drain();

    // Reset mid-run aborts without a result pulse.
    k = cyc;
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    while (cyc < k + 15) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("abort_result", data_result, '0);
    chk("abort_remainder", data_remainder, '0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
    drain();

    // Back-to-back: ctrl_DIV held high across the first result.
    begin
      exp_t x;
      k = cyc;
      data_operandA = 32'd35;
      data_operandB = 32'd16;
      ctrl_DIV      = 1'b1;
      x.res = 32'd2; x.rem = 32'd3; x.exc = 1'b0; x.cyc = k + W + 2;
      sb.push_back(x);
      x.res = 32'd1; x.rem = 32'd2; x.exc = 1'b0; x.cyc = k + 2 * (W + 2);
      sb.push_back(x);
      while (cyc < k + 10) @(negedge clock);
      data_operandA = 32'd6;
      data_operandB = 32'd4;
      while (cyc < k + W + 3) @(negedge clock);
      ctrl_DIV = 1'b0;
      drain();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; WIDTH SHALL be a power of two ≥ 8.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_operandA  input  WIDTH  dividend, two's complement.
REQ-005 data_operandB  input  WIDTH  divisor, two's complement.
REQ-006 ctrl_DIV  input  1  start request, sampled on rising edge.
REQ-007 data_result  output  WIDTH  quotient, two's complement.
REQ-008 data_remainder  output  WIDTH  remainder, two's complement.
REQ-009 data_exception  output  1  divide-by-zero or overflow flag for the current result.
REQ-010 data_resultRDY  output  1  one-cycle pulse: result/remainder/exception valid.
REQ-011 busy  output  1  high while a division is in progress.

Function
REQ-012 FSM states SHALL be IDLE, RUN, DONE; encoding SHALL be internal.
REQ-013 IDLE or DONE with ctrl_DIV=1 at an edge: latch both operands, clear exception, go to RUN, unless REQ-017/REQ-018 applies.
REQ-014 RUN: one restoring-division step per cycle on operand magnitudes, MSB first, for exactly WIDTH cycles; step counter SHALL run 0..WIDTH-1 then go to DONE.
REQ-015 ctrl_DIV during RUN SHALL be ignored; latched operands SHALL not change.
REQ-016 Sign rules: quotient negative iff operand signs differ and quotient magnitude ≠ 0; remainder takes dividend sign; |remainder| < |divisor|.
REQ-017 Divisor = 0: skip RUN, go to DONE next edge; data_result=0, data_remainder=dividend, data_exception=1.
REQ-018 Dividend = most-negative value and divisor = -1: skip RUN, go to DONE next edge; data_result=most-negative value, data_remainder=0, data_exception=1.
REQ-019 Latency: start sampled at edge N; data_resultRDY SHALL be high in the cycle after edge N+WIDTH+1 for normal operation, and after edge N+1 for REQ-017/REQ-018.
REQ-020 data_resultRDY SHALL be high only in DONE, exactly one cycle per division.
REQ-021 DONE with ctrl_DIV=0 SHALL go to IDLE.
REQ-022 DONE with ctrl_DIV=1 SHALL go to RUN (back-to-back start) while the previous result is presented.
REQ-023 data_result, data_remainder and data_exception SHALL be registered and hold until the next DONE.
REQ-024 busy SHALL be high exactly in RUN.

Reset
REQ-025 reset=1 SHALL force IDLE, step counter 0, all outputs 0, latched operands 0, asynchronously.
REQ-026 reset asserted mid-RUN SHALL abort without a data_resultRDY pulse; first ctrl_DIV after reset release SHALL start a fresh division.

Structure
REQ-027 Shared package div_pkg SHALL hold the FSM state typedef, default WIDTH, and most-negative-value constant.
REQ-028 One sub-module div_step (combinational: partial remainder, divisor, next dividend bit -> new partial remainder, quotient bit) SHALL be instantiated once.
REQ-029 Step counter width SHALL be log2(WIDTH)+1 bits.

Verification
REQ-030 35 / 16, start pulse one cycle -> after 33 cycles data_resultRDY=1, data_result=2, data_remainder=3, data_exception=0, busy low.
REQ-031 -35 / 16 -> data_result=0xFFFFFFFE, data_remainder=0xFFFFFFFD; 35 / -16 -> 0xFFFFFFFE, 3.
REQ-032 7 / 0 -> data_resultRDY two edges after start, data_result=0, data_remainder=7, data_exception=1; 0x80000000 / 0xFFFFFFFF -> 0x80000000, 0, data_exception=1.
REQ-033 Start 100/7, re-pulse ctrl_DIV with 9/3 at cycle 10 -> ignored; result 14, remainder 2.
REQ-034 Start 100/7, assert reset at cycle 15 -> outputs 0, no data_resultRDY; after release start 9/3 -> 3, 0.
REQ-035 Hold ctrl_DIV high with 35/16 then 6/4 -> back-to-back results 2/3 then 1/2, each data_resultRDY one cycle.
